// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared types and constants for the CSR access controller.
//   csr_op_t      : CSR instruction operation (RW / RS / RC)
//   priv_mode_t   : privilege level encoding (U / S / M)
//   ctrl_state_t  : controller FSM states
//   *_FIELD_*     : CSR address sub-fields (minimum privilege, access type)
// ---------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_TWRITE
  } ctrl_state_t;

  // addr[9:8] holds the lowest privilege allowed to touch the CSR
  localparam int PRIV_FIELD_HI = 9;
  localparam int PRIV_FIELD_LO = 8;
  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam int ACC_FIELD_HI  = 11;
  localparam int ACC_FIELD_LO  = 10;
  localparam logic [1:0] ACC_READ_ONLY = 2'b11;

  // Set/clear operations are the ones whose write can be elided
  function automatic logic is_set_clear(input csr_op_t op);
    return (op == CSR_OP_RS) || (op == CSR_OP_RC);
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// ---------------------------------------------------------------------------
// csr_rmw_alu
// Combinational read-modify-write unit for CSR instructions.
// Ports:
//   i_op        in  2     operation (csr_op_t encoding)
//   i_old       in  XLEN  current CSR value
//   i_src       in  XLEN  source operand (rs1 value or zero-extended imm)
//   i_src_zero  in  1     source register index / immediate is zero
//   o_new       out XLEN  value to write back
//   o_suppress  out 1     write must not happen (RS/RC with zero source)
// ---------------------------------------------------------------------------
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_zero,
  output logic [XLEN-1:0] o_new,
  output logic            o_suppress
);

  csr_op_t w_op;
  assign w_op = csr_op_t'(i_op);

  always_comb begin
    o_new = i_src;
    case (w_op)
      CSR_OP_RS: o_new = i_old | i_src;
      CSR_OP_RC: o_new = i_old & ~i_src;
      default:   o_new = i_src;
    endcase
  end

  // Suppression is keyed on the source *index* being zero, not on the value
  assign o_suppress = is_set_clear(w_op) && i_src_zero;

endmodule

// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
// Sequences CSR instructions (read, legality check, read-modify-write,
// response) against a CSR file, and optionally accepts direct writes from a
// trap unit which take priority over instructions when both arrive in IDLE.
//
// Configuration macro: CSR_TRAP_PORT_EN
//   defined   -> trap write port and TWRITE state are active
//   undefined -> trap_ready tied low, trap inputs ignored
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   instr_valid / instr_ready    instruction request handshake
//   instr_op, instr_use_imm, instr_imm, instr_rs1_val, instr_rs1_is_x0,
//   instr_addr, instr_priv       instruction fields
//   resp_valid / resp_ready      response handshake
//   resp_rdata, resp_illegal     old CSR value (0 if illegal), illegal flag
//   trap_valid / trap_ready, trap_addr, trap_wdata   trap-unit write port
//   csr_rd_en, csr_wr_en, csr_addr, csr_wdata        CSR file control
//   csr_rdata, csr_exists        CSR file read data / implemented flag
// ---------------------------------------------------------------------------
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic                  instr_use_imm,
  input  logic [4:0]            instr_imm,
  input  logic [XLEN-1:0]       instr_rs1_val,
  input  logic                  instr_rs1_is_x0,
  input  logic [CSR_ADDR_W-1:0] instr_addr,
  input  logic [1:0]            instr_priv,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_illegal,
  input  logic                  trap_valid,
  output logic                  trap_ready,
  input  logic [CSR_ADDR_W-1:0] trap_addr,
  input  logic [XLEN-1:0]       trap_wdata,
  output logic                  csr_rd_en,
  output logic                  csr_wr_en,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_wdata,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic                  csr_exists
);

  ctrl_state_t           r_state;
  logic                  r_csr_rd_en;
  logic                  r_csr_wr_en;
  logic [CSR_ADDR_W-1:0] r_csr_addr;
  logic [XLEN-1:0]       r_csr_wdata;
  logic                  r_resp_valid;
  logic [XLEN-1:0]       r_resp_rdata;
  logic                  r_resp_illegal;
  logic [1:0]            r_op;
  logic [1:0]            r_priv;
  logic [XLEN-1:0]       r_src;
  logic                  r_src_zero;

  logic                  w_idle;
  logic                  w_acc_instr;
  logic [XLEN-1:0]       w_new_val;
  logic                  w_suppress;
  logic                  w_illegal;

  // Ready is gated by reset so every output reads 0 while reset is held
  assign w_idle = (r_state == ST_IDLE) && !reset;

`ifdef CSR_TRAP_PORT_EN
  logic w_acc_trap;
  assign trap_ready  = w_idle;
  assign instr_ready = w_idle && !trap_valid;
  assign w_acc_trap  = trap_valid && w_idle;
`else
  logic w_trap_unused;
  assign trap_ready    = 1'b0;
  assign instr_ready   = w_idle;
  assign w_trap_unused = ^{trap_valid, trap_addr, trap_wdata};
`endif

  assign w_acc_instr = instr_valid && instr_ready;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .i_op       (r_op),
    .i_old      (csr_rdata),
    .i_src      (r_src),
    .i_src_zero (r_src_zero),
    .o_new      (w_new_val),
    .o_suppress (w_suppress)
  );

  // Read-only violation only counts when a write would actually happen,
  // so csrrs/csrrc with a zero source remain legal reads of RO CSRs.
  assign w_illegal = !csr_exists
                  || (r_priv < r_csr_addr[PRIV_FIELD_HI:PRIV_FIELD_LO])
                  || (!w_suppress &&
                      (r_csr_addr[ACC_FIELD_HI:ACC_FIELD_LO] == ACC_READ_ONLY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_csr_rd_en    <= 1'b0;
      r_csr_wr_en    <= 1'b0;
      r_csr_addr     <= '0;
      r_csr_wdata    <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_illegal <= 1'b0;
      r_op           <= 2'b00;
      r_priv         <= 2'b00;
      r_src          <= '0;
      r_src_zero     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
`ifdef CSR_TRAP_PORT_EN
          if (w_acc_trap) begin
            r_state     <= ST_TWRITE;
            r_csr_wr_en <= 1'b1;
            r_csr_addr  <= trap_addr;
            r_csr_wdata <= trap_wdata;
          end else
`endif
          if (w_acc_instr) begin
            r_state     <= ST_READ;
            r_csr_rd_en <= 1'b1;
            r_csr_addr  <= instr_addr;
            r_op        <= instr_op;
            r_priv      <= instr_priv;
            r_src       <= instr_use_imm ? {{(XLEN-5){1'b0}}, instr_imm}
                                         : instr_rs1_val;
            r_src_zero  <= instr_use_imm ? (instr_imm == 5'd0)
                                         : instr_rs1_is_x0;
          end
        end
        // csr_rdata is combinational on csr_addr, so old value, legality
        // and the write-back value are all resolved at the end of READ.
        ST_READ: begin
          r_state        <= ST_WRITE;
          r_csr_rd_en    <= 1'b0;
          r_csr_wr_en    <= !w_illegal && !w_suppress;
          r_csr_wdata    <= w_new_val;
          r_resp_rdata   <= w_illegal ? '0 : csr_rdata;
          r_resp_illegal <= w_illegal;
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_csr_wr_en  <= 1'b0;
          r_resp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
`ifdef CSR_TRAP_PORT_EN
        ST_TWRITE: begin
          r_state     <= ST_IDLE;
          r_csr_wr_en <= 1'b0;
        end
`endif
        default: begin
          r_state     <= ST_IDLE;
          r_csr_rd_en <= 1'b0;
          r_csr_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign csr_rd_en    = r_csr_rd_en;
  assign csr_wr_en    = r_csr_wr_en;
  assign csr_addr     = r_csr_addr;
  assign csr_wdata    = r_csr_wdata;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_illegal = r_resp_illegal;

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter XLEN, default 32, meaning CSR and register data width.
REQ-002 Parameter CSR_ADDR_W, default 12, meaning CSR address width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 instr_valid  in  1  CSR instruction request; instr_ready  out  1  request accepted.
REQ-007 instr_op  in  2  encoding 01 RW, 10 RS, 11 RC; instr_use_imm  in  1  5-bit immediate source.
REQ-008 instr_imm  in  5  immediate; instr_rs1_val  in  XLEN  register source; instr_rs1_is_x0  in  1  rs1 index is zero.
REQ-009 instr_addr  in  CSR_ADDR_W  target CSR; instr_priv  in  2  current privilege (0 U, 1 S, 3 M).
REQ-010 resp_valid  out  1  result ready; resp_ready  in  1  consumer accepts; resp_rdata  out  XLEN  old CSR value; resp_illegal  out  1  illegal-instruction flag.
REQ-011 trap_valid  in  1  trap-unit write request; trap_ready  out  1  accepted; trap_addr  in  CSR_ADDR_W; trap_wdata  in  XLEN.
REQ-012 csr_rd_en  out  1; csr_wr_en  out  1; csr_addr  out  CSR_ADDR_W; csr_wdata  out  XLEN; csr_rdata  in  XLEN (combinational from CSR file); csr_exists  in  1  addressed CSR implemented.

Function
REQ-013 FSM states IDLE, READ, WRITE, RESP, TWRITE; reset state IDLE.
REQ-014 IDLE: trap_ready=1; instr_ready = !trap_valid; trap accept -> TWRITE; instr accept -> READ; both valid same cycle -> trap wins.
REQ-015 Accept latches addr, op, source, priv; source = use_imm ? zero-extended imm : rs1_val.
REQ-016 READ (one cycle): csr_rd_en=1, csr_addr=latched addr; capture csr_rdata and legality; -> WRITE.
REQ-017 Write suppressed when op is RS/RC and source index is zero (rs1_is_x0, or imm==0 when use_imm).
REQ-018 Illegal when: !csr_exists, or priv < addr[9:8], or unsuppressed write with addr[11:10]==2'b11.
REQ-019 WRITE (one cycle): csr_wr_en=1 only if legal and not suppressed; csr_wdata = RW src, RS old|src, RC old&~src; -> RESP.
REQ-020 RESP: resp_valid=1, resp_rdata = captured old value (0 if illegal), resp_illegal held; stay until resp_ready, then -> IDLE.
REQ-021 Instruction latency accept-to-resp_valid is exactly 3 cycles; back-to-back throughput one per 4 cycles with resp_ready high.
REQ-022 TWRITE (one cycle): csr_wr_en=1, csr_addr=trap_addr, csr_wdata=trap_wdata, no privilege/read-only check, no response; -> IDLE.
REQ-023 Trap requests arriving while not IDLE wait (trap_ready=0); an in-flight instruction is never aborted by a trap.
REQ-024 csr_rd_en, csr_wr_en, resp_valid are 0 in every state not listed as driving them.

Reset
REQ-025 reset asserted at any time forces IDLE asynchronously; all outputs 0 (resp_rdata, csr_addr, csr_wdata included); in-flight transaction discarded, no partial write after release.

Configuration
REQ-026 Macro CSR_TRAP_PORT_EN: defined -> trap port and TWRITE present as above; undefined -> trap_ready tied 0, trap inputs ignored, TWRITE absent, instr_ready=1 in IDLE.

Structure
REQ-027 Package csr_pkg holds csr_op_t, priv_mode_t, ctrl state enum, address field constants (priv field [9:8], read-only code 2'b11).
REQ-028 Sub-module csr_rmw_alu (combinational op, old, src -> new value, write-suppress flag) instantiated once.

Verification
REQ-029 RW addr 0x340 priv M, rs1_val 0xDEADBEEF, csr_rdata 0x12345678 -> wr 0xDEADBEEF at cycle 2, resp_rdata 0x12345678 at cycle 3.
REQ-030 RS imm 5'h0F, old 0xF0 -> wdata 0xFF; RC imm 0 -> no csr_wr_en, resp_rdata old, not illegal.
REQ-031 RW addr 0xC00 (read-only) -> illegal, no write, resp_rdata 0; RS rs1_is_x0 on 0xC00 -> legal, read only.
REQ-032 priv U access to 0x300 -> resp_illegal=1; csr_exists=0 at priv M -> resp_illegal=1.
REQ-033 trap_valid and instr_valid same cycle (macro defined) -> trap written first, instr accepted next IDLE cycle; trap during RESP stalls until return to IDLE.
REQ-034 reset pulse during WRITE -> csr_wr_en and resp_valid drop immediately, FSM IDLE, no write after release; resp_ready held low 5 cycles -> resp_valid and data stable.
